// File: rtl/switch_fabric_cfg_sequencer_pkg.sv
// Shared types and helpers for the switch fabric context sequencer.
// Covers port indices, routing-word layout and nibble legality.
package sf_cfg_pkg;

  localparam int PORT_A     = 0;
  localparam int PORT_B     = 1;
  localparam int PORT_C     = 2;
  localparam int PORT_D     = 3;
  localparam int PORT_E     = 4;
  localparam int NUM_PORTS  = 5;
  localparam int SF_VEC_W   = 4;
  localparam int CTX_DATA_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } sf_state_e;

  function automatic logic nibble_legal(
    input logic [SF_VEC_W-1:0] n
  );
    return ($countones(n) <= 1);
  endfunction

  function automatic logic [SF_VEC_W-1:0] port_field(
    input logic [CTX_DATA_W-1:0] w,
    input int                    p
  );
    return w[p*SF_VEC_W +: SF_VEC_W];
  endfunction

  function automatic logic word_legal(
    input logic [CTX_DATA_W-1:0] w
  );
    logic ok;
    ok = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++)
      ok = ok & nibble_legal(port_field(w, p));
    return ok;
  endfunction

endpackage

// File: rtl/switch_fabric_cfg_sequencer_if.sv
// Host-side bus of the context sequencer: table writes,
// sequence control, status and the fabric select vectors.
interface switch_fabric_cfg_sequencer_if
  import sf_cfg_pkg::*;
#(
  parameter int CTX_AW  = 3,
  parameter int DWELL_W = 8
);

  logic                  cfg_we;
  logic [CTX_AW-1:0]     cfg_addr;
  logic [CTX_DATA_W-1:0] cfg_data;
  logic [DWELL_W-1:0]    cfg_dwell;
  logic                  cfg_err;
  logic                  start;
  logic                  abort;
  logic [CTX_AW-1:0]     last_ctx;
  logic                  loop_en;
  logic                  busy;
  logic                  done;
  logic [CTX_AW-1:0]     cur_ctx;
  logic [SF_VEC_W-1:0]   sf_cfg_vecA;
  logic [SF_VEC_W-1:0]   sf_cfg_vecB;
  logic [SF_VEC_W-1:0]   sf_cfg_vecC;
  logic [SF_VEC_W-1:0]   sf_cfg_vecD;
  logic [SF_VEC_W-1:0]   sf_cfg_vecE;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_dwell,
    output start, abort, last_ctx, loop_en,
    input  cfg_err, busy, done, cur_ctx,
    input  sf_cfg_vecA, sf_cfg_vecB, sf_cfg_vecC,
    input  sf_cfg_vecD, sf_cfg_vecE
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_dwell,
    input  start, abort, last_ctx, loop_en,
    output cfg_err, busy, done, cur_ctx,
    output sf_cfg_vecA, sf_cfg_vecB, sf_cfg_vecC,
    output sf_cfg_vecD, sf_cfg_vecE
  );

endinterface

// File: rtl/switch_fabric_cfg_sequencer_ctx_mem.sv
// Context table: routing word plus dwell per entry, cleared on
// reset, one write port and one combinational read port.
module sf_cfg_ctx_mem
  import sf_cfg_pkg::*;
#(
  parameter int NUM_CTX = 8,
  parameter int CTX_AW  = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [CTX_AW-1:0]     i_waddr,
  input  logic [CTX_DATA_W-1:0] i_wdata,
  input  logic [DWELL_W-1:0]    i_wdwell,
  input  logic [CTX_AW-1:0]     i_raddr,
  output logic [CTX_DATA_W-1:0] o_rdata,
  output logic [DWELL_W-1:0]    o_rdwell
);

  logic [CTX_DATA_W-1:0] r_data  [NUM_CTX];
  logic [DWELL_W-1:0]    r_dwell [NUM_CTX];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        r_data[i]  <= '0;
        r_dwell[i] <= '0;
      end
    end else if (i_we) begin
      r_data[i_waddr]  <= i_wdata;
      r_dwell[i_waddr] <= i_wdwell;
    end
  end

  // Read sees pre-write contents, so a same-cycle write never
  // leaks into the context being applied.
  assign o_rdata  = r_data[i_raddr];
  assign o_rdwell = r_dwell[i_raddr];

endmodule

// File: rtl/switch_fabric_cfg_sequencer.sv
// Steps the fabric through stored routing contexts, holding
// each for dwell+1 cycles, optionally looping, then idles it.
module switch_fabric_cfg_sequencer
  import sf_cfg_pkg::*;
#(
  parameter int NUM_CTX = 8,
  parameter int CTX_AW  = 3,
  parameter int DWELL_W = 8
) (
  input  logic clk,
  input  logic reset,
  switch_fabric_cfg_sequencer_if.slave bus
);

  sf_state_e             r_state;
  sf_state_e             w_state_nxt;
  logic [CTX_DATA_W-1:0] r_vec;
  logic [CTX_DATA_W-1:0] w_vec_nxt;
  logic [DWELL_W-1:0]    r_cnt;
  logic [DWELL_W-1:0]    w_cnt_nxt;
  logic [CTX_AW-1:0]     r_cur;
  logic [CTX_AW-1:0]     w_cur_nxt;
  logic [CTX_AW-1:0]     r_last;
  logic [CTX_AW-1:0]     w_last_nxt;
  logic [CTX_AW-1:0]     w_rd_idx;
  logic                  w_apply;
  logic                  r_err;
  logic                  w_wr_legal;
  logic [CTX_DATA_W-1:0] w_rd_data;
  logic [DWELL_W-1:0]    w_rd_dwell;

  assign w_wr_legal = word_legal(bus.cfg_data);

  sf_cfg_ctx_mem #(
    .NUM_CTX (NUM_CTX),
    .CTX_AW  (CTX_AW),
    .DWELL_W (DWELL_W)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .i_we     (bus.cfg_we & w_wr_legal),
    .i_waddr  (bus.cfg_addr),
    .i_wdata  (bus.cfg_data),
    .i_wdwell (bus.cfg_dwell),
    .i_raddr  (w_rd_idx),
    .o_rdata  (w_rd_data),
    .o_rdwell (w_rd_dwell)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_cur   <= '0;
      r_last  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cur   <= w_cur_nxt;
      r_last  <= w_last_nxt;
      r_err   <= bus.cfg_we & ~w_wr_legal;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    w_last_nxt  = r_last;
    w_rd_idx    = '0;
    w_apply     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state_nxt = ST_RUN;
          w_last_nxt  = bus.last_ctx;
          w_apply     = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
          w_vec_nxt   = '0;
          w_cnt_nxt   = '0;
          w_cur_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (r_cur < r_last) begin
          w_rd_idx = r_cur + 1'b1;
          w_apply  = 1'b1;
        end else if (bus.loop_en) begin
          w_apply = 1'b1;
        end else begin
          w_state_nxt = ST_FINISH;
          w_vec_nxt   = '0;
          w_cur_nxt   = '0;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_apply) begin
      w_vec_nxt = w_rd_data;
      w_cnt_nxt = w_rd_dwell;
      w_cur_nxt = w_rd_idx;
    end
  end

  assign bus.sf_cfg_vecA = port_field(r_vec, PORT_A);
  assign bus.sf_cfg_vecB = port_field(r_vec, PORT_B);
  assign bus.sf_cfg_vecC = port_field(r_vec, PORT_C);
  assign bus.sf_cfg_vecD = port_field(r_vec, PORT_D);
  assign bus.sf_cfg_vecE = port_field(r_vec, PORT_E);
  assign bus.busy        = (r_state == ST_RUN);
  assign bus.done        = (r_state == ST_FINISH);
  assign bus.cur_ctx     = r_cur;
  assign bus.cfg_err     = r_err;

endmodule

// File: tb/tb_switch_fabric_cfg_sequencer.sv
// Bench for the context sequencer: vector table, directed
// corner sequences and random traffic against a segment model.
module tb_switch_fabric_cfg_sequencer;

  localparam int NCTX = 8;
  localparam int AW   = 3;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  switch_fabric_cfg_sequencer_if #(.CTX_AW(AW), .DWELL_W(DW)) sf_if ();

  switch_fabric_cfg_sequencer #(
    .NUM_CTX (NCTX),
    .CTX_AW  (AW),
    .DWELL_W (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sf_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference: table contents plus the context segment in progress.
  logic [19:0] m_tbl [NCTX];
  int          m_dw  [NCTX];
  bit          m_run, m_fin, m_err;
  int          m_ctx, m_last, m_left;
  logic [19:0] m_word;

  typedef struct {
    bit          start;
    logic [19:0] vec;
    bit          busy;
    bit          done;
    logic [2:0]  cur;
  } vec_t;
  vec_t tv [6];

  function automatic bit legal(logic [19:0] w);
    for (int p = 0; p < 5; p++)
      if ($countones(w[p*4 +: 4]) > 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [19:0] dut_vec();
    return {sf_if.sf_cfg_vecE, sf_if.sf_cfg_vecD, sf_if.sf_cfg_vecC,
            sf_if.sf_cfg_vecB, sf_if.sf_cfg_vecA};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCTX; i++) begin
      m_tbl[i] = '0;
      m_dw[i]  = 0;
    end
    m_run = 0; m_fin = 0; m_err = 0;
    m_ctx = 0; m_last = 0; m_left = 0; m_word = '0;
  endtask

  task automatic apply(int n);
    m_ctx  = n;
    m_word = m_tbl[n];
    m_left = m_dw[n] + 1;
  endtask

  task automatic model_step();
    bit fin_n;
    fin_n = 0;
    if (!m_run) begin
      if (!m_fin && sf_if.start && !sf_if.abort) begin
        m_run  = 1;
        m_last = int'(sf_if.last_ctx);
        apply(0);
      end
    end else if (sf_if.abort) begin
      m_run = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_ctx < m_last) apply(m_ctx + 1);
        else if (sf_if.loop_en) apply(0);
        else begin
          m_run = 0;
          fin_n = 1;
        end
      end
    end
    m_fin = fin_n;
    m_err = 0;
    if (sf_if.cfg_we) begin
      if (legal(sf_if.cfg_data)) begin
        m_tbl[sf_if.cfg_addr] = sf_if.cfg_data;
        m_dw[sf_if.cfg_addr]  = int'(sf_if.cfg_dwell);
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic check_model();
    logic [31:0] act, exp;
    act = 32'({dut_vec(), sf_if.busy, sf_if.done, sf_if.cur_ctx, sf_if.cfg_err});
    exp = 32'({m_run ? m_word : 20'h0, m_run, m_fin,
               m_run ? 3'(m_ctx) : 3'd0, m_err});
    check("model", act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_model();
    sf_if.cfg_we = 1'b0;
    sf_if.start  = 1'b0;
    sf_if.abort  = 1'b0;
  endtask

  task automatic wr(int a, logic [19:0] d, int dw);
    sf_if.cfg_we    = 1'b1;
    sf_if.cfg_addr  = 3'(a);
    sf_if.cfg_data  = d;
    sf_if.cfg_dwell = 8'(dw);
    tick();
  endtask

  task automatic wait_done(string name, int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (sf_if.done) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  function automatic logic [19:0] rnd_word();
    logic [19:0] w;
    int r;
    for (int p = 0; p < 5; p++) begin
      r = $urandom_range(0, 9);
      if (r == 0) w[p*4 +: 4] = 4'h0;
      else if (r < 5) w[p*4 +: 4] = 4'(1 << (r - 1));
      else w[p*4 +: 4] = 4'($urandom_range(0, 15));
    end
    return w;
  endfunction

  initial begin
    tv[0] = '{1, 20'h00001, 1, 0, 3'd0};
    tv[1] = '{0, 20'h00001, 1, 0, 3'd0};
    tv[2] = '{0, 20'h00001, 1, 0, 3'd0};
    tv[3] = '{0, 20'h00020, 1, 0, 3'd1};
    tv[4] = '{0, 20'h00000, 0, 1, 3'd0};
    tv[5] = '{0, 20'h00000, 0, 0, 3'd0};

    sf_if.cfg_we = 0; sf_if.cfg_addr = 0; sf_if.cfg_data = 0;
    sf_if.cfg_dwell = 0; sf_if.start = 0; sf_if.abort = 0;
    sf_if.last_ctx = 0; sf_if.loop_en = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check("reset", 32'({dut_vec(), sf_if.busy, sf_if.done,
                        sf_if.cur_ctx, sf_if.cfg_err}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic sequence from the vector table
    wr(0, 20'h00001, 2);
    wr(1, 20'h00020, 0);
    sf_if.last_ctx = 3'd1;
    sf_if.loop_en  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sf_if.start = tv[i].start;
      tick();
      check($sformatf("tv%0d", i),
            32'({dut_vec(), sf_if.busy, sf_if.done, sf_if.cur_ctx}),
            32'({tv[i].vec, tv[i].busy, tv[i].done, tv[i].cur}));
    end

    // Two looped passes, loop_en dropped during the second
    begin
      int b, c1;
      bit gap, seen;
      b = 1; c1 = 0; gap = 0; seen = 0;
      sf_if.loop_en = 1'b1;
      sf_if.start   = 1'b1;
      tick();
      for (int i = 0; i < 20 && !seen; i++) begin
        if (i == 5) sf_if.loop_en = 1'b0;
        tick();
        if (sf_if.done) seen = 1;
        else begin
          if (sf_if.busy) b++;
          else gap = 1;
          if (sf_if.cur_ctx == 3'd1) c1++;
        end
      end
      check("loop_done", 32'(seen), 32'd1);
      check("loop_busy_cycles", 32'(b), 32'd8);
      check("loop_ctx1_passes", 32'(c1), 32'd2);
      check("loop_busy_gap", 32'(gap), 32'd0);
    end
    tick();

    // Illegal write keeps the prior entry
    begin
      bit hit;
      hit = 0;
      wr(2, 20'h00100, 0);
      wr(2, 20'h00003, 1);
      check("err_pulse", 32'(sf_if.cfg_err), 32'd1);
      tick();
      check("err_clear", 32'(sf_if.cfg_err), 32'd0);
      sf_if.last_ctx = 3'd2;
      sf_if.start    = 1'b1;
      tick();
      for (int i = 0; i < 10 && !hit; i++) begin
        tick();
        if (sf_if.cur_ctx == 3'd2) begin
          hit = 1;
          check("illegal_keep", 32'(dut_vec()), 32'h00100);
        end
      end
      check("illegal_reached", 32'(hit), 32'd1);
      wait_done("illegal_done", 10);
      tick();
    end

    // Abort on second cycle of ctx0, then start+abort in idle
    sf_if.last_ctx = 3'd1;
    sf_if.start    = 1'b1;
    tick();
    tick();
    sf_if.abort = 1'b1;
    tick();
    check("abort_clear", 32'({dut_vec(), sf_if.busy, sf_if.done}), 32'd0);
    sf_if.start = 1'b1;
    sf_if.abort = 1'b1;
    tick();
    check("abort_wins", 32'({sf_if.busy, sf_if.done}), 32'd0);
    repeat (4) tick();

    // Live rewrite of ctx1 while it is applied in a looped run
    sf_if.loop_en = 1'b1;
    sf_if.start   = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("live_old", 32'({dut_vec(), sf_if.cur_ctx}), 32'({20'h00020, 3'd1}));
    wr(1, 20'h80000, 0);
    tick();
    tick();
    tick();
    check("live_new", 32'({dut_vec(), sf_if.cur_ctx}), 32'({20'h80000, 3'd1}));
    sf_if.loop_en = 1'b0;
    wait_done("live_done", 20);

    // Reset mid-sequence, then the cleared table runs as zeros
    sf_if.loop_en  = 1'b1;
    sf_if.start    = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_mid", 32'({dut_vec(), sf_if.busy, sf_if.done,
                          sf_if.cur_ctx, sf_if.cfg_err}), 32'd0);
    #1;
    reset = 1'b0;
    sf_if.loop_en  = 1'b0;
    sf_if.last_ctx = 3'd7;
    sf_if.start    = 1'b1;
    begin
      int b;
      b = 0;
      for (int i = 0; i < 9; i++) begin
        tick();
        if (sf_if.busy) b++;
      end
      check("zero_tbl_busy", 32'(b), 32'd8);
      check("zero_tbl_done", 32'(sf_if.done), 32'd1);
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        sf_if.cfg_we    = 1'b1;
        sf_if.cfg_addr  = 3'($urandom_range(0, 7));
        sf_if.cfg_data  = rnd_word();
        sf_if.cfg_dwell = 8'($urandom_range(0, 3));
      end
      sf_if.start = ($urandom_range(0, 9) == 0);
      sf_if.abort = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0)
        sf_if.last_ctx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)
        sf_if.loop_en = ~sf_if.loop_en;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
